// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives a 1-cycle-latency BRAM and hands {pc, instr} to decode
// over valid/ready, with a skid entry so back-pressure never loses a returning word.
module fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [31:0]       out_instr
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic              skid_valid_q, skid_valid_d;
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic [31:0]       skid_instr_q, skid_instr_d;

   logic              issue;
   logic [ADDR_W-1:0] redirect_target;

   assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

   // Holding off issue while out is stalled with a word in flight keeps the skid free for it.
   assign issue     = !rst && !skid_valid_q && !(inflight_q && out_valid_q && !out_ready);
   assign imem_en   = issue;
   assign imem_addr = redirect_valid ? redirect_target : pc_q;

   assign out_valid = out_valid_q;
   assign out_pc    = out_pc_q;
   assign out_instr = out_instr_q;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      out_valid_d   = out_valid_q;
      out_pc_d      = out_pc_q;
      out_instr_d   = out_instr_q;
      skid_valid_d  = skid_valid_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;

      if (issue) begin
         pc_d          = imem_addr + ADDR_W'(4);
         inflight_pc_d = imem_addr;
      end else if (redirect_valid) begin
         pc_d = redirect_target;
      end

      if (redirect_valid) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_pc_d     = skid_pc_q;
            out_instr_d  = skid_instr_q;
            skid_valid_d = inflight_q;
            if (inflight_q) begin
               skid_pc_d    = inflight_pc_q;
               skid_instr_d = imem_dout;
            end
         end else if (inflight_q) begin
            out_valid_d = 1'b1;
            out_pc_d    = inflight_pc_q;
            out_instr_d = imem_dout;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (inflight_q) begin
         skid_valid_d = 1'b1;
         skid_pc_d    = inflight_pc_q;
         skid_instr_d = imem_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_instr_q   <= '0;
         skid_valid_q  <= 1'b0;
         skid_pc_q     <= '0;
         skid_instr_q  <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         out_valid_q   <= out_valid_d;
         out_pc_q      <= out_pc_d;
         out_instr_q   <= out_instr_d;
         skid_valid_q  <= skid_valid_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, mid-stream reset, PC wrap.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   logic [31:0] ram [0:255];
   logic [63:0] xfer_log [$];
   logic [63:0] exp_log [0:6];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_dout      (imem_dout),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   // BRAM model: resets its output to all-ones, holds dout when not enabled
   always @(posedge clk) begin
      if (rst)
         imem_dout <= 32'hFFFF_FFFF;
      else if (imem_en)
         imem_dout <= ram[imem_addr[9:2]];
   end

   always @(posedge clk) begin
      if (!rst && !redirect_valid && out_valid && out_ready) begin
         xfer_log.push_back({out_pc, out_instr});
         $display("xfer pc=%h instr=%h", out_pc, out_instr);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, " valid"}, 64'(out_valid), 64'd1);
      chk({tag, " pc"}, 64'(out_pc), 64'(pc));
      chk({tag, " instr"}, 64'(out_instr), 64'(instr));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
      exp_log[0] = {32'h0000_0000, 32'hC0DE_0000};
      exp_log[1] = {32'h0000_0004, 32'hC0DE_0001};
      exp_log[2] = {32'h0000_0008, 32'hC0DE_0002};
      exp_log[3] = {32'h0000_0000, 32'hC0DE_0000};
      exp_log[4] = {32'h0000_0004, 32'hC0DE_0001};
      exp_log[5] = {32'hFFFF_FFFC, 32'hC0DE_00FF};
      exp_log[6] = {32'h0000_0000, 32'hC0DE_0000};

      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      repeat (3) cyc();
      chk("rst en", 64'(imem_en), 64'd0);
      chk("rst valid", 64'(out_valid), 64'd0);
      chk("rst pc", 64'(out_pc), 64'd0);
      chk("rst instr", 64'(out_instr), 64'd0);

      // Stream from reset
      rst = 1'b0; #1;
      chk("c0 en", 64'(imem_en), 64'd1);
      chk("c0 addr", 64'(imem_addr), 64'h0);
      chk("c0 valid", 64'(out_valid), 64'd0);
      cyc(); #1;
      chk("c1 addr", 64'(imem_addr), 64'h4);
      chk("c1 valid", 64'(out_valid), 64'd0);
      cyc(); #1;
      chk_out("c2 out", 32'h0, 32'hC0DE_0000);
      chk("c2 addr", 64'(imem_addr), 64'h8);

      // Back-pressure for three cycles
      cyc(); out_ready = 1'b0; #1;
      chk_out("c3 out", 32'h4, 32'hC0DE_0001);
      chk("c3 en", 64'(imem_en), 64'd0);
      cyc(); #1;
      chk_out("c4 out", 32'h4, 32'hC0DE_0001);
      chk("c4 en", 64'(imem_en), 64'd0);
      cyc(); #1;
      chk_out("c5 out", 32'h4, 32'hC0DE_0001);
      cyc(); out_ready = 1'b1; #1;
      chk_out("c6 out", 32'h4, 32'hC0DE_0001);
      chk("c6 en", 64'(imem_en), 64'd0);
      cyc(); #1;
      chk_out("c7 out", 32'h8, 32'hC0DE_0002);
      chk("c7 addr", 64'(imem_addr), 64'hC);
      chk("c7 en", 64'(imem_en), 64'd1);
      cyc(); #1;
      chk("c8 valid", 64'(out_valid), 64'd0);
      chk("c8 addr", 64'(imem_addr), 64'h10);

      // Reset mid-stream with a fetch in flight
      cyc();
      chk_out("c9 out", 32'hC, 32'hC0DE_0003);
      rst = 1'b1; #1;
      chk("c9 rst en", 64'(imem_en), 64'd0);
      cyc();
      chk("f0 valid", 64'(out_valid), 64'd0);
      rst = 1'b0; #1;
      chk("f0 en", 64'(imem_en), 64'd1);
      chk("f0 addr", 64'(imem_addr), 64'h0);
      cyc(); #1;
      chk("f1 valid", 64'(out_valid), 64'd0);
      chk("f1 addr", 64'(imem_addr), 64'h4);
      cyc(); #1;
      chk_out("f2 out", 32'h0, 32'hC0DE_0000);
      cyc(); #1;
      chk_out("f3 out", 32'h4, 32'hC0DE_0001);

      // Redirect while C presented and D in flight
      cyc();
      chk_out("f4 out", 32'h8, 32'hC0DE_0002);
      redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
      chk("f4 redir addr", 64'(imem_addr), 64'h40);
      chk("f4 redir en", 64'(imem_en), 64'd1);
      cyc(); redirect_valid = 1'b0; #1;
      chk("f5 valid", 64'(out_valid), 64'd0);
      chk("f5 addr", 64'(imem_addr), 64'h44);
      cyc(); #1;
      chk_out("f6 out", 32'h40, 32'hC0DE_0010);

      // Redirect during a full stall
      out_ready = 1'b0; #1;
      chk("f6 en", 64'(imem_en), 64'd0);
      cyc();
      chk_out("f7 out", 32'h40, 32'hC0DE_0010);
      redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
      chk("f7 en", 64'(imem_en), 64'd0);
      chk("f7 addr", 64'(imem_addr), 64'h80);
      cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
      chk("f8 valid", 64'(out_valid), 64'd0);
      chk("f8 en", 64'(imem_en), 64'd1);
      chk("f8 addr", 64'(imem_addr), 64'h80);
      cyc(); #1;
      chk("f9 valid", 64'(out_valid), 64'd0);
      chk("f9 addr", 64'(imem_addr), 64'h84);

      // PC wrap at top of address space
      cyc();
      chk_out("f10 out", 32'h80, 32'hC0DE_0020);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
      chk("f10 addr", 64'(imem_addr), 64'hFFFF_FFFC);
      cyc(); redirect_valid = 1'b0; #1;
      chk("f11 addr wrap", 64'(imem_addr), 64'h0);
      chk("f11 valid", 64'(out_valid), 64'd0);
      cyc(); #1;
      chk_out("f12 out", 32'hFFFF_FFFC, 32'hC0DE_00FF);
      cyc(); #1;
      chk_out("f13 out", 32'h0, 32'hC0DE_0000);
      cyc(); out_ready = 1'b0;
      repeat (3) cyc();

      chk("xfer count", 64'(xfer_log.size()), 64'd7);
      for (int i = 0; i < 7; i++) begin
         if (i < xfer_log.size())
            chk($sformatf("xfer %0d", i), xfer_log[i], exp_log[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
